// File: rtl/restoring_divider_pkg.sv
// Shared constants for the restoring divider.
//   state_t          : 2-bit FSM encoding (IDLE / CALC / DONE)
//   DBZ_QUOTIENT_BIT : fill value for the quotient of a divide-by-zero,
//                      replicated to the operand width by the user
package restoring_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic DBZ_QUOTIENT_BIT = 1'b1;

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division iteration, purely combinational.
// The incoming quotient bit is shifted into the partial remainder. The
// divisor is then trial-subtracted at WIDTH+1 bits. A borrow keeps the
// shifted value (restore) and yields quotient bit 0. No borrow keeps the
// difference and yields quotient bit 1.
//   i_rem   : partial remainder (always < divisor, so WIDTH bits carry it)
//   i_q_bit : dividend bit shifted in this iteration
//   i_div   : divisor
//   o_rem   : next partial remainder
//   o_q_bit : quotient bit produced by this iteration
module restoring_div_step
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_q_bit,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;
    logic           w_borrow;

    assign w_shift  = {i_rem, i_q_bit};
    assign w_trial  = w_shift - {1'b0, i_div};
    assign w_borrow = w_trial[WIDTH];

    // Both candidates are < divisor after selection, so the top bit is zero.
    assign o_rem   = w_borrow ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign o_q_bit = ~w_borrow;

endmodule

// File: rtl/restoring_divider.sv
// Iterative unsigned divider. It produces one quotient bit per clock using
// the restoring_div_step datapath. A controller drives it with a
// start/done handshake.
//
//   state | meaning
//   IDLE  | waiting for Start_i, results held
//   CALC  | iterating, one quotient bit per cycle, Busy_o high
//   DONE  | single cycle, Done_o high, a new start is accepted here
//
// Ports:
//   Clk_i, Rst_i      : clock, async active-high reset
//   Start_i           : request; sampled only in IDLE or DONE
//   Dividend_i        : numerator, captured on an accepted start
//   Divisor_i         : denominator, captured on an accepted start
//   Busy_o            : high while in CALC
//   Done_o            : one-cycle pulse when the results are valid
//   Quotient_o        : quotient, held until the next completion
//   Remainder_o       : remainder, held until the next completion
//   DivByZero_o       : the last accepted operation had a zero divisor
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk_i,
    input  logic             Rst_i,
    input  logic             Start_i,
    input  logic [WIDTH-1:0] Dividend_i,
    input  logic [WIDTH-1:0] Divisor_i,
    output logic             Busy_o,
    output logic             Done_o,
    output logic [WIDTH-1:0] Quotient_o,
    output logic [WIDTH-1:0] Remainder_o,
    output logic             DivByZero_o
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot_out;
    logic [WIDTH-1:0] r_rem_out;
    logic             r_dbz;

    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;

    restoring_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem   (r_rem),
        .i_q_bit (r_q[WIDTH-1]),
        .i_div   (r_div),
        .o_rem   (w_rem_next),
        .o_q_bit (w_q_bit)
    );

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_q        <= '0;
            r_rem      <= '0;
            r_div      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_quot_out <= '0;
            r_rem_out  <= '0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    if (Start_i) begin
                        if (Divisor_i == '0) begin
                            // Zero divisor completes at once, no iterations.
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_quot_out <= {WIDTH{DBZ_QUOTIENT_BIT}};
                            r_rem_out  <= Dividend_i;
                            r_dbz      <= 1'b1;
                        end else begin
                            r_state <= ST_CALC;
                            r_busy  <= 1'b1;
                            r_div   <= Divisor_i;
                            r_q     <= Dividend_i;
                            r_rem   <= '0;
                            r_cnt   <= CNT_W'(WIDTH);
                        end
                    end
                end
                ST_CALC: begin
                    r_q   <= {r_q[WIDTH-2:0], w_q_bit};
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_quot_out <= {r_q[WIDTH-2:0], w_q_bit};
                        r_rem_out  <= w_rem_next;
                        r_dbz      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy_o      = r_busy;
    assign Done_o      = r_done;
    assign Quotient_o  = r_quot_out;
    assign Remainder_o = r_rem_out;
    assign DivByZero_o = r_dbz;

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;

    logic clk;
    logic rst;

    logic        s8_start;
    logic [7:0]  s8_a, s8_b;
    logic        s8_busy, s8_done, s8_dbz;
    logic [7:0]  s8_q, s8_r;

    logic        s32_start;
    logic [31:0] s32_a, s32_b;
    logic        s32_busy, s32_done, s32_dbz;
    logic [31:0] s32_q, s32_r;

    int n_tests;
    int n_fail;

    restoring_divider #(.WIDTH(8)) dut8 (
        .Clk_i       (clk),
        .Rst_i       (rst),
        .Start_i     (s8_start),
        .Dividend_i  (s8_a),
        .Divisor_i   (s8_b),
        .Busy_o      (s8_busy),
        .Done_o      (s8_done),
        .Quotient_o  (s8_q),
        .Remainder_o (s8_r),
        .DivByZero_o (s8_dbz)
    );

    restoring_divider #(.WIDTH(32)) dut32 (
        .Clk_i       (clk),
        .Rst_i       (rst),
        .Start_i     (s32_start),
        .Dividend_i  (s32_a),
        .Divisor_i   (s32_b),
        .Busy_o      (s32_busy),
        .Done_o      (s32_done),
        .Quotient_o  (s32_q),
        .Remainder_o (s32_r),
        .DivByZero_o (s32_dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: plain integer division; a zero divisor gives all-ones and the dividend.
    function automatic void ref_div(input longint unsigned a, input longint unsigned b,
                                    input int width, output longint unsigned q,
                                    output longint unsigned r, output bit z);
        longint unsigned mask;
        mask = (64'd1 << width) - 64'd1;
        z = (b == 0);
        q = z ? mask : a / b;
        r = z ? a : a % b;
    endfunction

    // Start an 8-bit operation, wait for Done_o, check everything.
    // immediate: drive Start_i now (used in the DONE cycle for back-to-back).
    // inject:    pulse a foreign start (50 / 5) in the middle of CALC.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input bit immediate, input bit inject, input bit pulse_chk);
        int lat;
        int bz;
        longint unsigned eq, er;
        bit ez;
        if (!immediate) begin
            @(posedge clk); #1;
        end
        s8_start = 1'b1; s8_a = a; s8_b = b;
        @(posedge clk); #1;
        s8_start = 1'b0; s8_a = 8'($urandom); s8_b = 8'($urandom);
        lat = 0; bz = 0;
        while (!s8_done && lat < 64) begin
            if (s8_busy) bz++;
            if (inject && lat == 3) begin
                s8_start = 1'b1; s8_a = 8'd50; s8_b = 8'd5;
            end else begin
                s8_start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        s8_start = 1'b0;
        ref_div(a, b, 8, eq, er, ez);
        check("w8_done_seen", s8_done, 1'b1);
        check("w8_latency",   lat, ez ? 0 : 8);
        check("w8_busy_cyc",  bz,  ez ? 0 : 8);
        check("w8_quotient",  s8_q, eq);
        check("w8_remainder", s8_r, er);
        check("w8_dbz",       s8_dbz, ez);
        if (pulse_chk) begin
            @(posedge clk); #1;
            check("w8_done_pulse", s8_done, 1'b0);
            check("w8_q_held",     s8_q, eq);
            check("w8_r_held",     s8_r, er);
        end
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b);
        int lat;
        longint unsigned eq, er;
        bit ez;
        @(posedge clk); #1;
        s32_start = 1'b1; s32_a = a; s32_b = b;
        @(posedge clk); #1;
        s32_start = 1'b0; s32_a = $urandom; s32_b = $urandom;
        lat = 0;
        while (!s32_done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        ref_div(a, b, 32, eq, er, ez);
        check("w32_done_seen", s32_done, 1'b1);
        check("w32_latency",   lat, ez ? 0 : 32);
        check("w32_quotient",  s32_q, eq);
        check("w32_remainder", s32_r, er);
        check("w32_dbz",       s32_dbz, ez);
    endtask

    initial begin
        int seen_done;
        logic [31:0] ra, rb;
        n_tests = 0; n_fail = 0;
        rst = 1'b1;
        s8_start = 1'b0;  s8_a = '0;  s8_b = '0;
        s32_start = 1'b0; s32_a = '0; s32_b = '0;
        #23 rst = 1'b0;
        #1;
        check("rst_busy", s8_busy, 1'b0);
        check("rst_done", s8_done, 1'b0);
        check("rst_q",    s8_q, 8'd0);
        check("rst_r",    s8_r, 8'd0);
        check("rst_dbz",  s8_dbz, 1'b0);
        check("rst_q32",  s32_q, 32'd0);

        run8(8'd100, 8'd7, 1'b0, 1'b0, 1'b1);
        run8(8'd5,   8'd9, 1'b0, 1'b0, 1'b1);
        run8(8'd255, 8'd1, 1'b0, 1'b0, 1'b1);
        run8(8'd0,   8'd3, 1'b0, 1'b0, 1'b1);
        run8(8'd200, 8'd0, 1'b0, 1'b0, 1'b1);
        run8(8'd10,  8'd3, 1'b0, 1'b0, 1'b1);

        // Mid-CALC start ignored, then a start accepted in the DONE cycle.
        run8(8'd100, 8'd7, 1'b0, 1'b1, 1'b0);
        run8(8'd81,  8'd9, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset between edges in the middle of CALC.
        @(posedge clk); #1;
        s8_start = 1'b1; s8_a = 8'd100; s8_b = 8'd7;
        @(posedge clk); #1;
        s8_start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre_rst_busy", s8_busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", s8_busy, 1'b0);
        check("arst_done", s8_done, 1'b0);
        check("arst_q",    s8_q, 8'd0);
        check("arst_r",    s8_r, 8'd0);
        check("arst_dbz",  s8_dbz, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (s8_done) seen_done++;
        end
        check("arst_no_done", seen_done, 0);
        run8(8'd37, 8'd6, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            run8(8'($urandom), 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
        end

        run32(32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run32(32'hFFFF_FFFF, 32'h0000_0001);
        run32(32'h1234_5678, 32'h0000_0000);
        run32(32'h0000_0003, 32'hFFFF_FFFF);
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run32(ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
